// File: rtl/lsu_mdu_wb_arbiter_pkg.sv
// Shared types and constants for the long-latency writeback arbiter.
package lsu_mdu_wb_arbiter_pkg;

   // Widths shared with the rest of the core's defines.
   localparam int WB_DATA_WIDTH      = 32;
   localparam int WB_REG_ADDR_WIDTH  = 5;
   localparam int WB_COMMIT_ID_WIDTH = 3;

   // Completing unit indices.
   localparam int SRC_MUL = 0;
   localparam int SRC_DIV = 1;
   localparam int SRC_LSU = 2;
   localparam int SRC_CSR = 3;

   // One buffered result. The we bit is already qualified with rd_addr != x0.
   typedef struct packed {
      logic [WB_REG_ADDR_WIDTH-1:0]  rd_addr;
      logic                          we;
      logic [WB_DATA_WIDTH-1:0]      data;
      logic [WB_COMMIT_ID_WIDTH-1:0] commit_id;
   } wb_entry_t;

   // Circular successor of a source index.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small per-source result buffer; head is visible combinationally, no pass-through.
module wb_result_fifo
   import lsu_mdu_wb_arbiter_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  wb_entry_t wdata_i,
   input  logic      pop_i,
   output logic      full_o,
   output logic      empty_o,
   output wb_entry_t head_o
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   wb_entry_t        mem_q [BUF_DEPTH];
   wb_entry_t        mem_d [BUF_DEPTH];
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the registered count, so a full buffer cannot take
   // a push in the cycle it pops.
   assign full_o  = (count_q == CNT_W'(BUF_DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next pointers, count and storage; power-of-two depth lets pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state: reset empties the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/lsu_mdu_wb_arbiter.sv
// Dual-slot writeback/commit arbiter for MUL, DIV, LSU and CSR results.
module lsu_mdu_wb_arbiter
   import lsu_mdu_wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC         = 4,
   parameter int BUF_DEPTH       = 2,
   parameter int DATA_WIDTH      = WB_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH  = WB_REG_ADDR_WIDTH,
   parameter int COMMIT_ID_WIDTH = WB_COMMIT_ID_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_SRC-1:0]                 src_valid_i,
   output logic [NUM_SRC-1:0]                 src_ready_o,
   input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  src_rd_addr_i,
   input  logic [NUM_SRC-1:0]                 src_rd_we_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data_i,
   input  logic [NUM_SRC*COMMIT_ID_WIDTH-1:0] src_commit_id_i,
   output logic                               wb0_we_o,
   output logic [REG_ADDR_WIDTH-1:0]          wb0_addr_o,
   output logic [DATA_WIDTH-1:0]              wb0_data_o,
   output logic                               wb1_we_o,
   output logic [REG_ADDR_WIDTH-1:0]          wb1_addr_o,
   output logic [DATA_WIDTH-1:0]              wb1_data_o,
   output logic                               commit_valid_o,
   output logic [COMMIT_ID_WIDTH-1:0]         commit_id_o,
   output logic                               commit_valid2_o,
   output logic [COMMIT_ID_WIDTH-1:0]         commit_id2_o
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   wb_entry_t            src_entry [NUM_SRC];
   wb_entry_t            head      [NUM_SRC];
   logic [NUM_SRC-1:0]   full, empty, push, pop;
   logic                 ready_en_q, ready_en_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 g0_vld, g1_vld, g1_grant;
   logic [IDX_W-1:0]     g0_idx, g1_idx;
   logic                 waw_hit, id_clash;

   logic                       wb0_we_q, wb0_we_d, wb1_we_q, wb1_we_d;
   logic [REG_ADDR_WIDTH-1:0]  wb0_addr_q, wb0_addr_d, wb1_addr_q, wb1_addr_d;
   logic [DATA_WIDTH-1:0]      wb0_data_q, wb0_data_d, wb1_data_q, wb1_data_d;
   logic                       cv0_q, cv0_d, cv1_q, cv1_d;
   logic [COMMIT_ID_WIDTH-1:0] cid0_q, cid0_d, cid1_q, cid1_d;

   // Unpack the flat source buses; x0 destinations never write the register file.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_entry[i].rd_addr   = src_rd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         src_entry[i].we        = src_rd_we_i[i] &&
                                  (src_rd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0);
         src_entry[i].data      = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         src_entry[i].commit_id = src_commit_id_i[i*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
      end
   end

   // Ready is held low through reset and the first cycle after it.
   assign src_ready_o = {NUM_SRC{ready_en_q}} & ~full;
   assign push        = src_valid_i & src_ready_o;
   assign ready_en_d  = 1'b1;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
      wb_result_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[s]),
         .wdata_i (src_entry[s]),
         .pop_i   (pop[s]),
         .full_o  (full[s]),
         .empty_o (empty[s]),
         .head_o  (head[s])
      );
   end

   // Round-robin pick of up to two heads; slot 1 is dropped on WAW or duplicate ID.
   always_comb begin
      logic [IDX_W-1:0] idx;
      idx      = '0;
      g0_vld   = 1'b0;
      g0_idx   = '0;
      g1_vld   = 1'b0;
      g1_idx   = '0;
      pop      = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_SRC);
         if (!g0_vld && !empty[idx]) begin
            g0_vld = 1'b1;
            g0_idx = idx;
         end
      end
      for (int k = 1; k < NUM_SRC; k++) begin
         idx = IDX_W'((int'(g0_idx) + k) % NUM_SRC);
         if (g0_vld && !g1_vld && !empty[idx]) begin
            g1_vld = 1'b1;
            g1_idx = idx;
         end
      end
      waw_hit  = head[g0_idx].we && head[g1_idx].we &&
                 (head[g0_idx].rd_addr == head[g1_idx].rd_addr);
      id_clash = (head[g0_idx].commit_id == head[g1_idx].commit_id);
      g1_grant = g1_vld && !waw_hit && !id_clash;
      if (g0_vld) begin
         pop[g0_idx] = 1'b1;
         rr_ptr_d    = IDX_W'(wrap_inc(int'(g0_idx), NUM_SRC));
      end
      if (g1_grant) begin
         pop[g1_idx] = 1'b1;
         rr_ptr_d    = IDX_W'(wrap_inc(int'(g1_idx), NUM_SRC));
      end
   end

   // Slot outputs: valid/we drop when idle, address/data/ID hold.
   always_comb begin
      wb0_we_d   = 1'b0;
      wb1_we_d   = 1'b0;
      cv0_d      = 1'b0;
      cv1_d      = 1'b0;
      wb0_addr_d = wb0_addr_q;
      wb1_addr_d = wb1_addr_q;
      wb0_data_d = wb0_data_q;
      wb1_data_d = wb1_data_q;
      cid0_d     = cid0_q;
      cid1_d     = cid1_q;
      if (g0_vld) begin
         cv0_d      = 1'b1;
         wb0_we_d   = head[g0_idx].we;
         wb0_addr_d = head[g0_idx].rd_addr;
         wb0_data_d = head[g0_idx].data;
         cid0_d     = head[g0_idx].commit_id;
      end
      if (g1_grant) begin
         cv1_d      = 1'b1;
         wb1_we_d   = head[g1_idx].we;
         wb1_addr_d = head[g1_idx].rd_addr;
         wb1_data_d = head[g1_idx].data;
         cid1_d     = head[g1_idx].commit_id;
      end
   end

   // Arbiter state and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_q <= 1'b0;
         rr_ptr_q   <= '0;
         wb0_we_q   <= 1'b0;
         wb1_we_q   <= 1'b0;
         wb0_addr_q <= '0;
         wb1_addr_q <= '0;
         wb0_data_q <= '0;
         wb1_data_q <= '0;
         cv0_q      <= 1'b0;
         cv1_q      <= 1'b0;
         cid0_q     <= '0;
         cid1_q     <= '0;
      end else begin
         ready_en_q <= ready_en_d;
         rr_ptr_q   <= rr_ptr_d;
         wb0_we_q   <= wb0_we_d;
         wb1_we_q   <= wb1_we_d;
         wb0_addr_q <= wb0_addr_d;
         wb1_addr_q <= wb1_addr_d;
         wb0_data_q <= wb0_data_d;
         wb1_data_q <= wb1_data_d;
         cv0_q      <= cv0_d;
         cv1_q      <= cv1_d;
         cid0_q     <= cid0_d;
         cid1_q     <= cid1_d;
      end
   end

   assign wb0_we_o        = wb0_we_q;
   assign wb0_addr_o      = wb0_addr_q;
   assign wb0_data_o      = wb0_data_q;
   assign wb1_we_o        = wb1_we_q;
   assign wb1_addr_o      = wb1_addr_q;
   assign wb1_data_o      = wb1_data_q;
   assign commit_valid_o  = cv0_q;
   assign commit_id_o     = cid0_q;
   assign commit_valid2_o = cv1_q;
   assign commit_id2_o    = cid1_q;

   // Two in-flight results must never share a commit ID.
   a_unique_commit_id: assert property (@(posedge clk) disable iff (rst) !(g1_vld && id_clash));

endmodule

// File: tb/tb_lsu_mdu_wb_arbiter.sv
// Directed bench with a per-source scoreboard and a negedge retire monitor.
module tb_lsu_mdu_wb_arbiter;

   localparam int NS = 4;
   localparam int RW = 5;
   localparam int DW = 32;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NS-1:0]   src_valid_i = '0;
   logic [NS-1:0]   src_ready_o;
   logic [NS*RW-1:0] src_rd_addr_i = '0;
   logic [NS-1:0]   src_rd_we_i = '0;
   logic [NS*DW-1:0] src_data_i = '0;
   logic [NS*IW-1:0] src_commit_id_i = '0;
   logic            wb0_we_o, wb1_we_o;
   logic [RW-1:0]   wb0_addr_o, wb1_addr_o;
   logic [DW-1:0]   wb0_data_o, wb1_data_o;
   logic            commit_valid_o, commit_valid2_o;
   logic [IW-1:0]   commit_id_o, commit_id2_o;

   typedef struct {
      logic [RW-1:0] addr;
      logic          we;
      logic [DW-1:0] data;
      logic [IW-1:0] id;
   } exp_t;

   exp_t exp_q [NS][$];
   int   n_vec = 0;
   int   n_err = 0;

   lsu_mdu_wb_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .src_valid_i     (src_valid_i),
      .src_ready_o     (src_ready_o),
      .src_rd_addr_i   (src_rd_addr_i),
      .src_rd_we_i     (src_rd_we_i),
      .src_data_i      (src_data_i),
      .src_commit_id_i (src_commit_id_i),
      .wb0_we_o        (wb0_we_o),
      .wb0_addr_o      (wb0_addr_o),
      .wb0_data_o      (wb0_data_o),
      .wb1_we_o        (wb1_we_o),
      .wb1_addr_o      (wb1_addr_o),
      .wb1_data_o      (wb1_data_o),
      .commit_valid_o  (commit_valid_o),
      .commit_id_o     (commit_id_o),
      .commit_valid2_o (commit_valid2_o),
      .commit_id2_o    (commit_id2_o)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one result on source s; if it is accepted, queue its expected retire.
   task automatic drive(input int s, input logic [RW-1:0] rd, input logic we,
                        input logic [DW-1:0] d, input logic [IW-1:0] id, output logic acc);
      exp_t e;
      src_valid_i[s]                 = 1'b1;
      src_rd_addr_i[s*RW +: RW]      = rd;
      src_rd_we_i[s]                 = we;
      src_data_i[s*DW +: DW]         = d;
      src_commit_id_i[s*IW +: IW]    = id;
      acc = src_ready_o[s];
      if (acc) begin
         e.addr = rd;
         e.we   = we && (rd != '0);
         e.data = d;
         e.id   = id;
         exp_q[s].push_back(e);
      end
   endtask

   task automatic sb_check(input string slot, input logic [IW-1:0] id, input logic we,
                           input logic [RW-1:0] addr, input logic [DW-1:0] data);
      int   hit;
      exp_t e;
      hit = -1;
      for (int s = 0; s < NS; s++)
         if (hit < 0 && exp_q[s].size() > 0 && exp_q[s][0].id == id) hit = s;
      chk({slot, "_known_id"}, 64'(hit >= 0), 64'd1);
      if (hit >= 0) begin
         e = exp_q[hit].pop_front();
         chk({slot, "_we"}, 64'(we), 64'(e.we));
         chk({slot, "_addr"}, 64'(addr), 64'(e.addr));
         chk({slot, "_data"}, 64'(data), 64'(e.data));
      end
   endtask

   // Retire monitor: every presented commit must match the head of some source's queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (commit_valid2_o) chk("slot1_without_slot0", 64'(commit_valid_o), 64'd1);
         if (commit_valid_o)
            sb_check("slot0", commit_id_o, wb0_we_o, wb0_addr_o, wb0_data_o);
         if (commit_valid2_o)
            sb_check("slot1", commit_id2_o, wb1_we_o, wb1_addr_o, wb1_data_o);
         if (commit_valid_o && commit_valid2_o && wb0_we_o && wb1_we_o)
            chk("waw_same_cycle", 64'(wb0_addr_o == wb1_addr_o), 64'd0);
      end
   end

   initial begin
      logic          acc;
      logic [DW-1:0] sd [NS];
      bit            pend [NS];
      bit            tog [NS];
      int            last [NS];
      bit            saw_nr;
      int            drain;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready_low", 64'(src_ready_o), 64'h0);
      chk("rst_commit_valid", 64'(commit_valid_o), 64'd0);
      chk("rst_wb0_data", 64'(wb0_data_o), 64'd0);
      rst = 1'b0;
      chk("release_ready_still_low", 64'(src_ready_o), 64'h0);
      step();
      chk("ready_after_release", 64'(src_ready_o), 64'hf);
      chk("idle_commit_valid", 64'(commit_valid_o), 64'd0);

      // MUL + LSU together from rr_ptr=0: both retire in one cycle
      drive(0, 5'd1, 1'b1, 32'h11, 3'd0, acc);
      chk("pair_mul_accept", 64'(acc), 64'd1);
      drive(2, 5'd2, 1'b1, 32'h22, 3'd1, acc);
      chk("pair_lsu_accept", 64'(acc), 64'd1);
      step();
      src_valid_i = '0;
      step();
      chk("pair_slot0_valid", 64'(commit_valid_o), 64'd1);
      chk("pair_slot0_id", 64'(commit_id_o), 64'd0);
      chk("pair_slot1_valid", 64'(commit_valid2_o), 64'd1);
      chk("pair_slot1_id", 64'(commit_id2_o), 64'd1);
      chk("pair_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);

      // Single MUL result: two-cycle latency, slot 1 idle
      drive(0, 5'd5, 1'b1, 32'h1234, 3'd3, acc);
      step();
      src_valid_i = '0;
      chk("single_not_yet", 64'(commit_valid_o), 64'd0);
      step();
      chk("single_valid", 64'(commit_valid_o), 64'd1);
      chk("single_id", 64'(commit_id_o), 64'd3);
      chk("single_we", 64'(wb0_we_o), 64'd1);
      chk("single_addr", 64'(wb0_addr_o), 64'd5);
      chk("single_data", 64'(wb0_data_o), 64'h1234);
      chk("single_slot1_idle", 64'(commit_valid2_o), 64'd0);
      chk("single_wb1_we", 64'(wb1_we_o), 64'd0);

      // DIV and CSR both write x7: serialised over two cycles
      drive(1, 5'd7, 1'b1, 32'hAAAA, 3'd2, acc);
      drive(3, 5'd7, 1'b1, 32'hBBBB, 3'd4, acc);
      step();
      src_valid_i = '0;
      step();
      chk("waw_first_id", 64'(commit_id_o), 64'd2);
      chk("waw_first_valid", 64'(commit_valid_o), 64'd1);
      chk("waw_first_alone", 64'(commit_valid2_o), 64'd0);
      step();
      chk("waw_second_id", 64'(commit_id_o), 64'd4);
      chk("waw_second_valid", 64'(commit_valid_o), 64'd1);
      chk("waw_second_alone", 64'(commit_valid2_o), 64'd0);

      // LSU store retires its ID without a register write
      drive(2, 5'd9, 1'b0, 32'h66, 3'd6, acc);
      step();
      src_valid_i = '0;
      step();
      chk("store_valid", 64'(commit_valid_o), 64'd1);
      chk("store_id", 64'(commit_id_o), 64'd6);
      chk("store_we", 64'(wb0_we_o), 64'd0);

      // rd=x0 with rd_we=1 must not write
      drive(0, 5'd0, 1'b1, 32'h55, 3'd5, acc);
      step();
      src_valid_i = '0;
      step();
      chk("x0_id", 64'(commit_id_o), 64'd5);
      chk("x0_we", 64'(wb0_we_o), 64'd0);

      // Reset with three results buffered: discard, clear outputs at once
      drive(0, 5'd10, 1'b1, 32'h100, 3'd0, acc);
      drive(1, 5'd11, 1'b1, 32'h101, 3'd1, acc);
      drive(2, 5'd12, 1'b1, 32'h102, 3'd2, acc);
      step();
      src_valid_i = '0;
      for (int s = 0; s < NS; s++) exp_q[s].delete();
      rst = 1'b1;
      #1;
      chk("midrst_commit_id", 64'(commit_id_o), 64'd0);
      chk("midrst_wb0_data", 64'(wb0_data_o), 64'd0);
      chk("midrst_valid", 64'(commit_valid_o), 64'd0);
      chk("midrst_ready_low", 64'(src_ready_o), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      chk("midrst_ready_after", 64'(src_ready_o), 64'hf);
      for (int i = 0; i < 4; i++) begin
         chk("midrst_no_commit", 64'(commit_valid_o | commit_valid2_o), 64'd0);
         step();
      end

      // All four units push every cycle
      saw_nr = 1'b0;
      for (int s = 0; s < NS; s++) begin
         pend[s] = 1'b0;
         tog[s]  = 1'b0;
         last[s] = 0;
      end
      for (int k = 0; k < 20; k++) begin
         for (int s = 0; s < NS; s++) begin
            if (!pend[s]) begin
               sd[s]   = $urandom;
               pend[s] = 1'b1;
            end
            drive(s, RW'(8 + s), 1'b1, sd[s], IW'(s * 2) + IW'(tog[s]), acc);
            if (acc) begin
               pend[s] = 1'b0;
               tog[s]  = ~tog[s];
            end else begin
               saw_nr = 1'b1;
            end
         end
         step();
         if (k >= 1) begin
            chk("stress_dual_retire", 64'({commit_valid_o, commit_valid2_o}), 64'd3);
            last[int'(commit_id_o >> 1)]  = k;
            last[int'(commit_id2_o >> 1)] = k;
         end
         if (k >= 3)
            for (int s = 0; s < NS; s++)
               chk("stress_starvation", 64'((k - last[s]) <= 2), 64'd1);
      end
      src_valid_i = '0;
      chk("stress_ready_dropped", 64'(saw_nr), 64'd1);

      // Drain with a bounded wait
      drain = 0;
      while (drain < 40 && (exp_q[0].size() + exp_q[1].size() +
                            exp_q[2].size() + exp_q[3].size()) != 0) begin
         step();
         drain++;
      end
      step();
      for (int s = 0; s < NS; s++)
         chk("drain_queue_empty", 64'(exp_q[s].size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
